// File: rtl/cpu_hazard_ctrl_if.sv
// Decode-side bundle for the hazard unit: decode fields and EX branch outcome in,
// pipeline controls, forwarding selects and performance counters out.
interface cpu_hazard_ctrl_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             dec_valid;
  logic [REG_W-1:0] dec_src1;
  logic [REG_W-1:0] dec_src2;
  logic             dec_src1_en;
  logic             dec_src2_en;
  logic             dec_wrt_en;
  logic [REG_W-1:0] dec_wrt_reg;
  logic             dec_is_load;
  logic             dec_is_branch;
  logic             br_taken;
  logic             cnt_clr;

  logic             stall;
  logic             bubble_idex;
  logic             flush_ifid;
  logic [2:0]       fwd_sel1;
  logic [2:0]       fwd_sel2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output dec_valid, dec_src1, dec_src2, dec_src1_en, dec_src2_en,
    output dec_wrt_en, dec_wrt_reg, dec_is_load, dec_is_branch,
    output br_taken, cnt_clr,
    input  stall, bubble_idex, flush_ifid, fwd_sel1, fwd_sel2,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_valid, dec_src1, dec_src2, dec_src1_en, dec_src2_en,
    input  dec_wrt_en, dec_wrt_reg, dec_is_load, dec_is_branch,
    input  br_taken, cnt_clr,
    output stall, bubble_idex, flush_ifid, fwd_sel1, fwd_sel2,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/cpu_hazard_ctrl.sv
// Pipeline hazard unit: shadow scoreboard of the stages after decode, RAW stall
// or forwarding selects, branch flush control and saturating stall/flush counters.
module cpu_hazard_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int REG_W      = 4,
  parameter int FWD_EN     = 0,
  parameter int BR_MODE    = 0,
  parameter int R0_ZERO    = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  cpu_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic             valid;
    logic             wrt_en;
    logic [REG_W-1:0] wrt_reg;
    logic             is_load;
    logic             is_branch;
  } sb_entry_t;

  sb_entry_t             sb_q [NUM_STAGES];
  sb_entry_t             sb_d [NUM_STAGES];
  logic                  active_q, active_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  logic [NUM_STAGES-1:0] match1, match2;
  logic                  raw_stall;
  logic                  flush_kill;
  logic                  stall;
  logic                  flush_ifid;
  logic [2:0]            fwd_sel1, fwd_sel2;

  // Lowest matching stage wins: it carries the most recent value of the register.
  function automatic logic [2:0] youngest(input logic [NUM_STAGES-1:0] m);
    logic [2:0] sel;
    sel = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (m[i]) sel = 3'(i + 1);
    end
    return sel;
  endfunction

  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      match1[i] = sb_q[i].valid & sb_q[i].wrt_en & hz.dec_src1_en &
                  (sb_q[i].wrt_reg == hz.dec_src1);
      match2[i] = sb_q[i].valid & sb_q[i].wrt_en & hz.dec_src2_en &
                  (sb_q[i].wrt_reg == hz.dec_src2);
    end
    if (R0_ZERO != 0) begin
      if (hz.dec_src1 == '0) match1 = '0;
      if (hz.dec_src2 == '0) match2 = '0;
    end
  end

  // active_q keeps every control low in the first cycle after reset release.
  always_comb begin
    if (FWD_EN != 0) raw_stall = sb_q[0].is_load & (match1[0] | match2[0]);
    else             raw_stall = (|match1) | (|match2);

    flush_kill = 1'b0;
    if (BR_MODE != 0)
      flush_kill = active_q & sb_q[0].valid & sb_q[0].is_branch & hz.br_taken;

    stall = active_q & raw_stall & hz.dec_valid & ~flush_kill;

    if (BR_MODE != 0)
      flush_ifid = flush_kill;
    else
      flush_ifid = active_q & ((hz.dec_valid & hz.dec_is_branch & ~stall) |
                               (sb_q[0].valid & sb_q[0].is_branch));

    fwd_sel1 = '0;
    fwd_sel2 = '0;
    if ((FWD_EN != 0) && active_q && !stall) begin
      fwd_sel1 = youngest(match1);
      fwd_sel2 = youngest(match2);
    end
  end

  always_comb begin
    sb_d[0] = '0;
    if (hz.dec_valid & ~stall & ~flush_kill) begin
      sb_d[0].valid     = 1'b1;
      sb_d[0].wrt_en    = hz.dec_wrt_en;
      sb_d[0].wrt_reg   = hz.dec_wrt_reg;
      sb_d[0].is_load   = hz.dec_is_load;
      sb_d[0].is_branch = hz.dec_is_branch;
    end
    for (int i = 1; i < NUM_STAGES; i++) sb_d[i] = sb_q[i-1];

    active_d = 1'b1;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != '1))      stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_ifid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) sb_q[i] <= '0;
      active_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) sb_q[i] <= sb_d[i];
      active_q    <= active_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall       = stall;
  assign hz.bubble_idex = stall | flush_kill;
  assign hz.flush_ifid  = flush_ifid;
  assign hz.fwd_sel1    = fwd_sel1;
  assign hz.fwd_sel2    = fwd_sel2;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Directed bench for cpu_hazard_ctrl: three configurations (stall-only, forwarding with
// predict-not-taken and r0 masking, deep pipe for counter saturation), checked via an expectation queue.
module tb_cpu_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [3:0] s1;
    logic       e1;
    logic [3:0] s2;
    logic       e2;
    logic       we;
    logic [3:0] wr;
    logic       ld;
    logic       br;
    logic       bt;
    logic       clr;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [2:0]  f1;
    logic [2:0]  f2;
    logic [15:0] sCnt;
    logic [15:0] fCnt;
  } obs_t;

  typedef struct packed {
    logic [1:0]  dut;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic [2:0]  f1;
    logic [2:0]  f2;
    logic        chkCnt;
    logic [15:0] sCnt;
    logic [15:0] fCnt;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  stim_t st0 = '0;
  stim_t st1 = '0;
  stim_t st2 = '0;
  int    checks = 0;
  int    errors = 0;
  exp_t  expQ[$];
  string tagQ[$];
  obs_t  ob0, ob1, ob2;

  always #5 clk = ~clk;

  cpu_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) if0 ();
  cpu_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) if1 ();
  cpu_hazard_ctrl_if #(.REG_W(4), .CNT_W(16)) if2 ();

  assign {if0.dec_valid, if0.dec_src1, if0.dec_src1_en, if0.dec_src2, if0.dec_src2_en, if0.dec_wrt_en,
          if0.dec_wrt_reg, if0.dec_is_load, if0.dec_is_branch, if0.br_taken, if0.cnt_clr} = st0;
  assign {if1.dec_valid, if1.dec_src1, if1.dec_src1_en, if1.dec_src2, if1.dec_src2_en, if1.dec_wrt_en,
          if1.dec_wrt_reg, if1.dec_is_load, if1.dec_is_branch, if1.br_taken, if1.cnt_clr} = st1;
  assign {if2.dec_valid, if2.dec_src1, if2.dec_src1_en, if2.dec_src2, if2.dec_src2_en, if2.dec_wrt_en,
          if2.dec_wrt_reg, if2.dec_is_load, if2.dec_is_branch, if2.br_taken, if2.cnt_clr} = st2;

  assign ob0 = {if0.stall, if0.bubble_idex, if0.flush_ifid, if0.fwd_sel1, if0.fwd_sel2, if0.stall_cnt, if0.flush_cnt};
  assign ob1 = {if1.stall, if1.bubble_idex, if1.flush_ifid, if1.fwd_sel1, if1.fwd_sel2, if1.stall_cnt, if1.flush_cnt};
  assign ob2 = {if2.stall, if2.bubble_idex, if2.flush_ifid, if2.fwd_sel1, if2.fwd_sel2, if2.stall_cnt, if2.flush_cnt};

  // u0: stall on any RAW, branch-shadow flush
  cpu_hazard_ctrl #(.NUM_STAGES(3), .REG_W(4), .FWD_EN(0), .BR_MODE(0), .R0_ZERO(0), .CNT_W(16))
    u0 (.clk(clk), .rst(rst), .hz(if0));
  // u1: forwarding, predict not-taken, r0 never hazards
  cpu_hazard_ctrl #(.NUM_STAGES(3), .REG_W(4), .FWD_EN(1), .BR_MODE(1), .R0_ZERO(1), .CNT_W(16))
    u1 (.clk(clk), .rst(rst), .hz(if1));
  // u2: deep pipe, stall on any RAW, predict not-taken
  cpu_hazard_ctrl #(.NUM_STAGES(6), .REG_W(4), .FWD_EN(0), .BR_MODE(1), .R0_ZERO(0), .CNT_W(16))
    u2 (.clk(clk), .rst(rst), .hz(if2));

  function automatic stim_t wrS(int r, int ld, int br);
    stim_t s;
    s    = '0;
    s.v  = 1'b1;
    s.we = 1'b1;
    s.wr = 4'(r);
    s.ld = 1'(ld);
    s.br = 1'(br);
    return s;
  endfunction

  function automatic stim_t rdS(int a, int ea, int b, int eb, int br);
    stim_t s;
    s    = '0;
    s.v  = 1'b1;
    s.s1 = 4'(a);
    s.e1 = 1'(ea);
    s.s2 = 4'(b);
    s.e2 = 1'(eb);
    s.br = 1'(br);
    return s;
  endfunction

  function automatic exp_t ex(int st, int bu, int fl, int a, int b);
    exp_t e;
    e        = '0;
    e.stall  = 1'(st);
    e.bubble = 1'(bu);
    e.flush  = 1'(fl);
    e.f1     = 3'(a);
    e.f2     = 3'(b);
    return e;
  endfunction

  function automatic exp_t exC(exp_t e, int sc, int fc);
    exp_t r;
    r        = e;
    r.chkCnt = 1'b1;
    r.sCnt   = 16'(sc);
    r.fCnt   = 16'(fc);
    return r;
  endfunction

  // Drive one DUT for a cycle (others idle) and queue what it must show.
  task automatic applyStimulus(input int d, input stim_t s, input logic r, input exp_t e, input string tag);
    @(negedge clk);
    rst = r;
    st0 = (d == 0) ? s : '0;
    st1 = (d == 1) ? s : '0;
    st2 = (d == 2) ? s : '0;
    e.dut = 2'(d);
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic chk(input string tag, input string what, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed %0h expected %0h", tag, what, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    obs_t  o;
    string tag;
    #1;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL queue_empty observed 0 entries expected 1");
      return;
    end
    e   = expQ.pop_front();
    tag = tagQ.pop_front();
    case (e.dut)
      2'd0:    o = ob0;
      2'd1:    o = ob1;
      default: o = ob2;
    endcase
    chk(tag, "stall",  16'(o.stall),  16'(e.stall));
    chk(tag, "bubble", 16'(o.bubble), 16'(e.bubble));
    chk(tag, "flush",  16'(o.flush),  16'(e.flush));
    chk(tag, "fwd1",   16'(o.f1),     16'(e.f1));
    chk(tag, "fwd2",   16'(o.f2),     16'(e.f2));
    if (e.chkCnt) begin
      chk(tag, "stall_cnt", o.sCnt, e.sCnt);
      chk(tag, "flush_cnt", o.fCnt, e.fCnt);
    end
  endtask

  task automatic step(input int d, input stim_t s, input logic r, input exp_t e, input string tag);
    applyStimulus(d, s, r, e, tag);
    checkOutput();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    stim_t s;
    exp_t  z;
    z = ex(0, 0, 0, 0, 0);
    #1 rst = 1'b1;

    $display("[TB] reset and release");
    step(0, rdS(0, 0, 0, 0, 1), 1'b1, exC(z, 0, 0), "rst_u0");
    step(1, '0,                 1'b1, exC(z, 0, 0), "rst_u1");
    step(2, '0,                 1'b1, exC(z, 0, 0), "rst_u2");
    step(0, rdS(0, 0, 0, 0, 1), 1'b0, z,            "release_u0");
    step(0, '0, 1'b0, exC(ex(0, 0, 1, 0, 0), 0, 0), "br_stage0");
    step(0, '0, 1'b0, exC(z, 0, 1),                 "br_done");

    $display("[TB] stall-only RAW on r3");
    step(0, wrS(3, 0, 0), 1'b0, z, "t1_wr");
    for (int i = 0; i < 3; i++) step(0, rdS(3, 1, 0, 0, 0), 1'b0, ex(1, 1, 0, 0, 0), "t1_stall");
    step(0, rdS(3, 1, 0, 0, 0), 1'b0, exC(z, 3, 1), "t1_go");

    $display("[TB] r0 hazard without masking");
    step(0, wrS(0, 0, 0), 1'b0, z, "r0u_wr");
    for (int i = 0; i < 3; i++) step(0, rdS(0, 1, 0, 0, 0), 1'b0, ex(1, 1, 0, 0, 0), "r0u_stall");
    step(0, rdS(0, 1, 0, 0, 0), 1'b0, exC(z, 6, 1), "r0u_go");

    $display("[TB] branch shadow flush with stall");
    step(0, wrS(7, 0, 1),       1'b0, ex(0, 0, 1, 0, 0), "bs_adv");
    step(0, rdS(7, 1, 0, 0, 0), 1'b0, ex(1, 1, 1, 0, 0), "bs_stall_flush");
    for (int i = 0; i < 2; i++) step(0, rdS(7, 1, 0, 0, 0), 1'b0, ex(1, 1, 0, 0, 0), "bs_stall");
    step(0, rdS(7, 1, 0, 0, 0), 1'b0, exC(z, 9, 3), "bs_go");
    step(0, wrS(8, 0, 0), 1'b0, z, "bh_wr");
    for (int i = 0; i < 3; i++) step(0, rdS(8, 1, 0, 0, 1), 1'b0, ex(1, 1, 0, 0, 0), "bh_hold");
    step(0, rdS(8, 1, 0, 0, 1), 1'b0, ex(0, 0, 1, 0, 0), "bh_adv");
    step(0, '0, 1'b0, ex(0, 0, 1, 0, 0), "bh_stage0");
    step(0, '0, 1'b0, exC(z, 12, 5),     "bh_done");

    $display("[TB] forwarding selects");
    step(1, wrS(5, 0, 0),       1'b0, z,                  "fw_wr5");
    step(1, rdS(5, 1, 0, 0, 0), 1'b0, ex(0, 0, 0, 1, 0),  "fw_sel1_1");
    step(1, wrS(6, 0, 0),       1'b0, z,                  "fw_wr6");
    step(1, '0,                 1'b0, z,                  "fw_nop");
    step(1, rdS(5, 1, 6, 1, 0), 1'b0, ex(0, 0, 0, 0, 2),  "fw_sel2_2");
    step(1, wrS(9, 0, 0),       1'b0, z,                  "fw_wr9a");
    step(1, wrS(9, 0, 0),       1'b0, z,                  "fw_wr9b");
    step(1, rdS(0, 0, 9, 1, 0), 1'b0, ex(0, 0, 0, 0, 1),  "fw_youngest");

    $display("[TB] load-use");
    step(1, wrS(2, 1, 0),       1'b0, z,                  "lu_load");
    step(1, rdS(2, 1, 9, 1, 0), 1'b0, ex(1, 1, 0, 0, 0),  "lu_stall");
    step(1, rdS(2, 1, 9, 1, 0), 1'b0, ex(0, 0, 0, 2, 0),  "lu_fwd");

    $display("[TB] r0 masked");
    step(1, wrS(0, 0, 0),       1'b0, z,                  "r0m_wr");
    step(1, rdS(0, 1, 0, 1, 0), 1'b0, z,                  "r0m_rd");
    step(1, '0,                 1'b0, exC(z, 1, 0),       "u1_cnt");

    $display("[TB] taken branch squashes decode");
    step(2, wrS(4, 0, 1), 1'b0, z, "bt_br");
    s = rdS(4, 1, 0, 0, 1);
    s.bt = 1'b1;
    step(2, s, 1'b0, ex(0, 1, 1, 0, 0), "bt_kill");
    s = '0;
    s.bt = 1'b1;
    step(2, s, 1'b0, z, "bt_stage0_empty");
    step(2, rdS(0, 0, 0, 0, 1), 1'b0, z, "nt_dec_br");
    step(2, '0, 1'b0, exC(z, 0, 1), "nt_stage0_br");
    repeat (8) @(negedge clk);

    $display("[TB] counter saturation");
    s = rdS(3, 1, 0, 0, 0);
    s.we = 1'b1;
    s.wr = 4'd3;
    step(2, s, 1'b0, z, "sat_start");
    repeat (76467) @(negedge clk);
    step(2, s, 1'b0, exC(z, 16'hFFFF, 1), "sat_full");
    s.clr = 1'b1;
    step(2, s, 1'b0, exC(ex(1, 1, 0, 0, 0), 16'hFFFF, 1), "clr_stall");
    s.clr = 1'b0;
    step(2, s, 1'b0, exC(ex(1, 1, 0, 0, 0), 0, 0), "clr_done");
    step(2, s, 1'b0, exC(ex(1, 1, 0, 0, 0), 1, 0), "cnt_restart");

    $display("[TB] reset mid-hazard");
    step(2, s, 1'b1, exC(z, 0, 0), "mid_rst");
    step(2, s, 1'b0, exC(z, 0, 0), "mid_release");
    step(2, s, 1'b0, ex(1, 1, 0, 0, 0), "mid_resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
